// File: rtl/quad_decoder_pkg.sv
// Shared types and helpers for the quadrature decoder: phase states, direction codes,
// and the mapping between phase states and filtered {A,B} levels.
package quad_decoder_pkg;

    typedef enum logic [2:0] {
        INIT,
        P00,
        P10,
        P11,
        P01
    } phase_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic phase_t phase_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return P00;
            2'b10:   return P10;
            2'b11:   return P11;
            default: return P01;
        endcase
    endfunction

    function automatic logic [1:0] ab_of(input phase_t p);
        case (p)
            P10:     return 2'b10;
            P11:     return 2'b11;
            P01:     return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Successor of a phase in the forward (count-up) direction: 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/qdec_filter.sv
// Per-channel synchronizer chain followed by a glitch filter that only follows the
// synchronized level after FILTER_LEN consecutive samples differing from its output.
module qdec_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic level,
    output logic level_next
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   sample;

    assign sample = sync_q[SYNC_STAGES-1];

    // The run counter restarts whenever the sample agrees with the output again.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        cnt_d  = '0;
        filt_d = filt_q;
        if (sample != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sample;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign level      = filt_q;
    assign level_next = filt_d;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B phase tracking, up/down position, sticky error.
// Define QUAD_DECODER_INDEX_EN to enable loading INDEX_VAL on a rising filtered index.
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int             N           = 8,
    parameter int             SYNC_STAGES = 2,
    parameter int             FILTER_LEN  = 3,
    parameter logic [N-1:0]   INDEX_VAL   = '0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         a_in,
    input  logic         b_in,
    input  logic         idx_in,
    input  logic         clear,
    input  logic         err_clr,
    output logic         step,
    output logic         dir,
    output logic [N-1:0] position,
    output logic         err
);

    localparam int INIT_CYC = SYNC_STAGES + FILTER_LEN;
    localparam int ICW      = $clog2(INIT_CYC + 1);

    logic a_lvl, b_lvl, a_nxt, b_nxt;
    logic idx_load;

    phase_t         state_q, state_d;
    logic [ICW-1:0] init_cnt_q, init_cnt_d;
    logic [N-1:0]   pos_q, pos_d;
    logic           step_q, step_d;
    logic           dir_q, dir_d;
    logic           err_q, err_d;

    logic [1:0] cur_ab, new_ab;
    logic       go_up, go_down, illegal;

    qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_a_filter (
        .clk(clk), .resetn(resetn), .din(a_in), .level(a_lvl), .level_next(a_nxt)
    );

    qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_b_filter (
        .clk(clk), .resetn(resetn), .din(b_in), .level(b_lvl), .level_next(b_nxt)
    );

`ifdef QUAD_DECODER_INDEX_EN
    logic idx_lvl, idx_nxt_unused;
    logic idx_prev_q, idx_prev_d;

    qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_idx_filter (
        .clk(clk), .resetn(resetn), .din(idx_in), .level(idx_lvl), .level_next(idx_nxt_unused)
    );

    always_comb idx_prev_d = idx_lvl;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) idx_prev_q <= 1'b0;
        else         idx_prev_q <= idx_prev_d;
    end

    assign idx_load = idx_lvl & ~idx_prev_q;
`else
    logic unused_idx;
    assign unused_idx = ^{idx_in, INDEX_VAL};
    assign idx_load   = 1'b0;
`endif

    // INIT exits on the same edge the filters settle, so it uses their next values.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        pos_d      = pos_q;
        step_d     = 1'b0;
        dir_d      = dir_q;
        err_d      = err_q;
        cur_ab     = ab_of(state_q);
        new_ab     = {a_lvl, b_lvl};
        go_up      = 1'b0;
        go_down    = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            INIT: begin
                if (init_cnt_q == ICW'(INIT_CYC - 1)) begin
                    state_d = phase_of({a_nxt, b_nxt});
                end else begin
                    init_cnt_d = init_cnt_q + ICW'(1);
                end
            end
            default: begin
                if (new_ab != cur_ab) begin
                    state_d = phase_of(new_ab);
                    if (new_ab == fwd_next(cur_ab))      go_up   = 1'b1;
                    else if (cur_ab == fwd_next(new_ab)) go_down = 1'b1;
                    else                                 illegal = 1'b1;
                end
            end
        endcase

        if (go_up || go_down) begin
            step_d = 1'b1;
            dir_d  = go_down ? DIR_DOWN : DIR_UP;
            pos_d  = go_down ? pos_q - N'(1) : pos_q + N'(1);
        end

        if (err_clr) err_d = 1'b0;
        if (illegal) err_d = 1'b1;

        if (clear)         pos_d = '0;
        else if (idx_load) pos_d = INDEX_VAL;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            pos_q      <= '0;
            step_q     <= 1'b0;
            dir_q      <= DIR_UP;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            pos_q      <= pos_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
        end
    end

    assign step     = step_q;
    assign dir      = dir_q;
    assign position = pos_q;
    assign err      = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios plus random quadrature
// traffic, compared every cycle against an edge-history reference model.
module tb_quad_decoder;

    localparam int            N        = 8;
    localparam int            SYNC     = 2;
    localparam int            FL       = 3;
    localparam int            INIT_CYC = SYNC + FL;
    localparam int            MAXE     = 16384;
    localparam logic [N-1:0]  IDX_VAL  = 8'h80;

    logic         clk     = 1'b0;
    logic         resetn  = 1'b0;
    logic         a_in    = 1'b0;
    logic         b_in    = 1'b0;
    logic         idx_in  = 1'b0;
    logic         clear   = 1'b0;
    logic         err_clr = 1'b0;
    logic         step, dir, err;
    logic [N-1:0] position;

    int n_vec = 0;
    int n_mis = 0;

    quad_decoder #(
        .N(N), .SYNC_STAGES(SYNC), .FILTER_LEN(FL), .INDEX_VAL(IDX_VAL)
    ) dut (
        .clk(clk), .resetn(resetn), .a_in(a_in), .b_in(b_in), .idx_in(idx_in),
        .clear(clear), .err_clr(err_clr), .step(step), .dir(dir),
        .position(position), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Reference model: raw samples per edge since reset; the filtered level at edge k
    // is derived from the window of samples taken SYNC edges earlier.
    logic [2:0]   samp [0:MAXE-1];
    int           ek;
    logic [2:0]   m_filt, m_filt_old;
    int           m_phase;
    logic [N-1:0] m_pos;
    logic         m_step, m_dir, m_err;
    bit           m_live = 1'b0;

    function automatic logic raw(input int ch, input int m);
        if (m < 1) return 1'b0;
        return samp[m][ch];
    endfunction

    function automatic logic filt_next(input int ch, input int k, input logic cur);
        logic x;
        x = raw(ch, k - SYNC);
        if (x == cur) return cur;
        for (int j = 1; j < FL; j++)
            if (raw(ch, k - SYNC - j) != x) return cur;
        return x;
    endfunction

    // Position within one electrical cycle: 00=0, 10=1, 11=2, 01=3.
    function automatic int gidx(input logic a, input logic b);
        if (a == b) return a ? 2 : 0;
        return a ? 1 : 3;
    endfunction

    always @(posedge clk or negedge resetn) begin : model
        logic [2:0] nf;
        int         k, g, d;
        logic       up, dn, bad, load;
        if (!resetn) begin
            ek         = 0;
            m_filt     = '0;
            m_filt_old = '0;
            m_phase    = -1;
            m_pos      = '0;
            m_step     = 1'b0;
            m_dir      = 1'b0;
            m_err      = 1'b0;
            m_live     = 1'b1;
        end else begin
            ek++;
            k = ek;
            samp[k] = {idx_in, a_in, b_in};
            for (int c = 0; c < 3; c++) nf[c] = filt_next(c, k, m_filt[c]);
            up  = 1'b0;
            dn  = 1'b0;
            bad = 1'b0;
            if (k == INIT_CYC) begin
                m_phase = gidx(nf[1], nf[0]);
            end else if (k > INIT_CYC) begin
                g = gidx(m_filt[1], m_filt[0]);
                d = (g - m_phase + 4) % 4;
                up  = (d == 1);
                dn  = (d == 3);
                bad = (d == 2);
                m_phase = g;
            end
            load = 1'b0;
`ifdef QUAD_DECODER_INDEX_EN
            load = m_filt[2] && !m_filt_old[2];
`endif
            m_step = up || dn;
            if (up || dn) m_dir = dn;
            if (err_clr) m_err = 1'b0;
            if (bad)     m_err = 1'b1;
            if (clear)     m_pos = '0;
            else if (load) m_pos = IDX_VAL;
            else if (up)   m_pos = m_pos + 8'd1;
            else if (dn)   m_pos = m_pos - 8'd1;
            m_filt_old = m_filt;
            m_filt     = nf;
        end
    end

    // Per-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (resetn && m_live) begin
            check("step", {31'b0, step}, {31'b0, m_step});
            check("dir", {31'b0, dir}, {31'b0, m_dir});
            check("position", {24'b0, position}, {24'b0, m_pos});
            check("err", {31'b0, err}, {31'b0, m_err});
        end
    end

    task automatic applyStimulus(input logic [1:0] ab);
        {a_in, b_in} = ab;
    endtask

    initial begin
        logic [1:0] fwd [4];
        int         kind;
        fwd[0] = 2'b10;
        fwd[1] = 2'b11;
        fwd[2] = 2'b01;
        fwd[3] = 2'b00;

        tick(2);
        resetn = 1'b1;
        tick(10);

        // Four forward steps, each checked for exact latency.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(fwd[i]);
            tick(5);
            check("lat_early", {31'b0, step}, 32'd0);
            tick(1);
            check("lat_step", {31'b0, step}, 32'd1);
            check("fwd_pos", {24'b0, position}, i + 1);
            tick(4);
        end
        check("fwd_dir", {31'b0, dir}, 32'd0);

        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clear_pos", {24'b0, position}, 32'd0);

        applyStimulus(2'b01);
        tick(6);
        check("rev_pos", {24'b0, position}, 32'd255);
        check("rev_dir", {31'b0, dir}, 32'd1);
        tick(4);
        applyStimulus(2'b00);
        tick(6);
        check("wrap_pos", {24'b0, position}, 32'd0);
        tick(4);
        applyStimulus(2'b10);
        tick(10);
        check("pre_err_pos", {24'b0, position}, 32'd1);

        // Illegal jump 10 -> 01 with err_clr asserted on the very edge it registers.
        applyStimulus(2'b01);
        tick(5);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("err_set", {31'b0, err}, 32'd1);
        check("err_nostep", {31'b0, step}, 32'd0);
        check("err_pos", {24'b0, position}, 32'd1);
        tick(3);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("err_clr", {31'b0, err}, 32'd0);

        // Two-cycle glitch on A must be swallowed; the phase stays at 01.
        a_in = 1'b1;
        tick(2);
        a_in = 1'b0;
        tick(10);
        check("glitch_pos", {24'b0, position}, 32'd1);
        applyStimulus(2'b00);
        tick(6);
        check("post_glitch_pos", {24'b0, position}, 32'd2);
        tick(4);

        // Reset in the middle of an in-flight edge, released with A=B=1.
        a_in = 1'b1;
        tick(3);
        resetn = 1'b0;
        #1;
        check("rst_pos", {24'b0, position}, 32'd0);
        check("rst_step", {31'b0, step}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        applyStimulus(2'b11);
        tick(2);
        resetn = 1'b1;
        tick(5);
        check("init11_step", {31'b0, step}, 32'd0);
        check("init11_err", {31'b0, err}, 32'd0);
        tick(5);
        applyStimulus(2'b01);
        tick(6);
        check("init11_fwd_step", {31'b0, step}, 32'd1);
        check("init11_fwd_pos", {24'b0, position}, 32'd1);
        tick(4);

`ifdef QUAD_DECODER_INDEX_EN
        applyStimulus(2'b00);
        idx_in = 1'b1;
        tick(6);
        check("idx_load", {24'b0, position}, {24'b0, IDX_VAL});
        tick(4);
        idx_in = 1'b0;
        tick(10);
        applyStimulus(2'b10);
        idx_in = 1'b1;
        tick(5);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("idx_clear", {24'b0, position}, 32'd0);
        tick(4);
        idx_in = 1'b0;
        tick(10);
`endif

        for (int it = 0; it < 300; it++) begin
            kind = $urandom_range(0, 15);
            if (kind < 9) begin
                if ($urandom_range(0, 1) == 1) a_in = ~a_in;
                else                           b_in = ~b_in;
            end else if (kind < 11) begin
                a_in = ~a_in;
                b_in = ~b_in;
            end else if (kind < 13) begin
                a_in = ~a_in;
                tick($urandom_range(1, FL));
                a_in = ~a_in;
            end else if (kind == 13) begin
                resetn = 1'b0;
                tick(1);
                resetn = 1'b1;
            end else begin
                idx_in = ~idx_in;
            end
            clear   = ($urandom_range(0, 19) == 0);
            err_clr = ($urandom_range(0, 7) == 0);
            tick(1);
            clear   = 1'b0;
            err_clr = 1'b0;
            tick($urandom_range(0, 11));
        end

        tick(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter N, default 8: position counter width in bits.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops per input (minimum 2).
REQ-003 Parameter FILTER_LEN, default 3: consecutive stable samples a filtered level needs before it changes (minimum 1).
REQ-004 Parameter INDEX_VAL, default 0: value of width N loaded on an index event.
REQ-005 clk  input  1  clock; all state on the rising edge.
REQ-006 resetn  input  1  reset: asynchronous, active-low.
REQ-007 a_in, b_in  input  1 each  raw quadrature channels, asynchronous to clk.
REQ-008 idx_in  input  1  raw index channel, asynchronous to clk.
REQ-009 clear  input  1  synchronous position clear.
REQ-010 err_clr  input  1  clears the sticky error flag.
REQ-011 step  output  1  one-cycle pulse per legal quadrature transition.
REQ-012 dir  output  1  direction of the last legal step: 0 = up, 1 = down; held between steps.
REQ-013 position  output  N  signed-agnostic up/down position count.
REQ-014 err  output  1  sticky illegal-transition flag.

Function
REQ-015 Each channel SHALL pass through a SYNC_STAGES synchronizer, then a glitch filter whose output takes the synchronized value only after FILTER_LEN consecutive equal samples that differ from the current output.
REQ-016 The phase FSM SHALL have states INIT, P00, P10, P11 and P01, named by the filtered {A,B} value.
REQ-017 INIT SHALL last exactly SYNC_STAGES+FILTER_LEN cycles after reset release, then enter the phase matching filtered {A,B} with no step and no err.
REQ-018 Forward sequence P00->P10->P11->P01->P00 SHALL pulse step, set dir=0, and increment position.
REQ-019 Reverse sequence (the opposite order) SHALL pulse step, set dir=1, and decrement position.
REQ-020 A two-bit change (P00<->P11, P10<->P01) SHALL set err, produce no step, leave dir and position unchanged, and move the FSM to the new phase.
REQ-021 Unchanged filtered {A,B} SHALL leave FSM, step and position unchanged.
REQ-022 Latency: a clean input edge SHALL produce step, together with the updated position and dir, at clock edge SYNC_STAGES+FILTER_LEN+1 after the first edge that samples it (6 with defaults).
REQ-023 Position SHALL wrap modulo 2^N: 2^N-1 + 1 -> 0 and 0 - 1 -> 2^N-1.
REQ-024 clear SHALL set position to 0 on the next edge and take priority over an index event and a step in the same cycle; step and dir still report the transition.
REQ-025 When err_clr is asserted in the same cycle as a new illegal transition, err SHALL remain 1.

Reset
REQ-026 Asserting resetn low SHALL immediately force: synchronizers and filters to 0, FSM to INIT, position=0, step=0, dir=0, err=0.
REQ-027 Reset asserted mid-sequence SHALL discard all in-flight samples; no step SHALL be emitted for edges seen before reset release.

Configuration
REQ-028 With macro QUAD_DECODER_INDEX_EN defined, idx_in SHALL be synchronized and filtered like the A and B channels, and a rising edge of filtered idx SHALL load INDEX_VAL into position; priority is clear > index > step.
REQ-029 Without QUAD_DECODER_INDEX_EN, the idx_in port SHALL still exist, SHALL be ignored, and no index logic SHALL be synthesized.

Structure
REQ-030 Package quad_decoder_pkg SHALL hold the phase-state enum typedef (INIT, P00, P10, P11, P01) and the DIR_UP=0 / DIR_DOWN=1 constants.
REQ-031 Sub-module qdec_filter (synchronizer plus glitch filter, parameters SYNC_STAGES and FILTER_LEN) SHALL be instantiated once per channel.

Verification
REQ-032 Reset with a_in=b_in=0; apply 4 forward quadrature steps spaced 10 cycles apart -> 4 step pulses, dir=0, position=4, each step 6 cycles after its edge.
REQ-033 From position=0, apply 1 reverse step -> position=255 (N=8), dir=1.
REQ-034 Toggle a_in and b_in in the same cycle -> err=1, no step, position unchanged; then pulse err_clr -> err=0.
REQ-035 Apply a 2-cycle glitch on a_in -> no step and no FSM change.
REQ-036 Release reset with a_in=b_in=1 -> FSM reaches P11 after 5 cycles, err=0, no step.
REQ-037 With QUAD_DECODER_INDEX_EN defined and INDEX_VAL=8'h80, present an idx rising edge together with a forward step -> position=8'h80; repeat with clear also asserted -> position=0.
